lif_neuron_layer: RTL and testbench

Parametrised layer of N_CH leaky integrate-and-fire neurons. It is the successor to the single fixed 8-bit spiking neuron at the top level. Each channel integrates an unsigned input current once per time-step strobe, applies a programmable shift-based leak, fires on a threshold crossing and then enters a programmable refractory period. Configuration is shared by all channels and is written through a small register port. A monitor mux and a layer spike counter are provided for debug via the bidirectional pins.

---
 rtl/lif_pkg.sv | 25 ++
 rtl/lif_neuron_core.sv | 58 +++++
 rtl/lif_neuron_layer.sv | 93 +++++++++
 tb/tb_lif_neuron_layer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared constants and helpers for the LIF neuron layer
package lif_pkg;

    localparam logic [1:0] CFG_THR  = 2'd0;
    localparam logic [1:0] CFG_LEAK = 2'd1;
    localparam logic [1:0] CFG_REF  = 2'd2;
    localparam logic [1:0] CFG_MODE = 2'd3;

    localparam int MODE_SUB = 0;
    localparam int MODE_EN  = 1;

    localparam int LEAK_W = 3;

    // Unsigned add clamped to the largest w-bit value.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] s;
        logic [32:0] max_v;
        s     = {1'b0, a} + {1'b0, b};
        max_v = (33'd1 << w) - 33'd1;
        return (s > max_v) ? max_v[31:0] : s[31:0];
    endfunction

endpackage

// File: rtl/lif_neuron_core.sv
// rtl/lif_neuron_core.sv - one leaky integrate-and-fire channel
module lif_neuron_core
    import lif_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int POT_W = 12,
    parameter int REF_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    input  logic [IN_W-1:0]   in_cur,
    input  logic [POT_W-1:0]  thr,
    input  logic [LEAK_W-1:0] leak_sh,
    input  logic [REF_W-1:0]  ref_per,
    input  logic              sub_mode,
    output logic [POT_W-1:0]  pot,
    output logic              spike
);

    logic [REF_W-1:0] ref_cnt;
    logic [POT_W-1:0] leaked;
    logic [POT_W-1:0] sum;
    logic             fire;

    // A zero shift would otherwise drain the whole potential, so it means no leak.
    always_comb begin
        leaked = pot;
        if (leak_sh != '0) begin
            leaked = pot - (pot >> leak_sh);
        end
        sum  = POT_W'(sat_add(32'(leaked), 32'(in_cur), POT_W));
        fire = (sum >= thr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pot     <= '0;
            ref_cnt <= '0;
            spike   <= 1'b0;
        end else begin
            spike <= 1'b0;
            if (step) begin
                if (ref_cnt != '0) begin
                    ref_cnt <= ref_cnt - REF_W'(1);
                    pot     <= '0;
                end else if (fire) begin
                    spike   <= 1'b1;
                    ref_cnt <= ref_per;
                    pot     <= sub_mode ? (sum - thr) : '0;
                end else begin
                    pot <= sum;
                end
            end
        end
    end

endmodule

// File: rtl/lif_neuron_layer.sv
// rtl/lif_neuron_layer.sv - layer of LIF neurons with shared config, monitor and spike counter
module lif_neuron_layer
    import lif_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int IN_W    = 8,
    parameter int POT_W   = 12,
    parameter int REF_W   = 3,
    parameter int THR_RST = 200,
    localparam int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 step_en,
    input  logic [N_CH*IN_W-1:0] in_cur,
    input  logic                 cfg_we,
    input  logic [1:0]           cfg_addr,
    input  logic [POT_W-1:0]     cfg_wdata,
    output logic [N_CH-1:0]      spike,
    input  logic [SEL_W-1:0]     mon_sel,
    output logic [POT_W-1:0]     mon_pot,
    output logic [7:0]           spike_total
);

    logic [POT_W-1:0]  thr;
    logic [LEAK_W-1:0] leak_sh;
    logic [REF_W-1:0]  ref_per;
    logic [1:0]        mode;
    logic              step_act;
    logic [POT_W-1:0]  pot_arr [N_CH];
    logic [7:0]        spike_cnt;

    // Cores see the registered config, so a write in a step cycle takes effect next step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr     <= POT_W'(THR_RST);
            leak_sh <= '0;
            ref_per <= '0;
            mode    <= 2'b10;
        end else if (cfg_we) begin
            case (cfg_addr)
                CFG_THR:  thr     <= cfg_wdata;
                CFG_LEAK: leak_sh <= cfg_wdata[LEAK_W-1:0];
                CFG_REF:  ref_per <= cfg_wdata[REF_W-1:0];
                CFG_MODE: mode    <= cfg_wdata[1:0];
                default:  ;
            endcase
        end
    end

    assign step_act = step_en & mode[MODE_EN];

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        lif_neuron_core #(
            .IN_W  (IN_W),
            .POT_W (POT_W),
            .REF_W (REF_W)
        ) u_core (
            .clk      (clk),
            .rst_n    (rst_n),
            .step     (step_act),
            .in_cur   (in_cur[k*IN_W +: IN_W]),
            .thr      (thr),
            .leak_sh  (leak_sh),
            .ref_per  (ref_per),
            .sub_mode (mode[MODE_SUB]),
            .pot      (pot_arr[k]),
            .spike    (spike[k])
        );
    end

    always_comb begin
        spike_cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            spike_cnt = spike_cnt + 8'(spike[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mon_pot     <= '0;
            spike_total <= '0;
        end else begin
            spike_total <= spike_total + spike_cnt;
            if (int'(mon_sel) < N_CH) begin
                mon_pot <= pot_arr[mon_sel];
            end else begin
                mon_pot <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lif_neuron_layer.sv
// tb/tb_lif_neuron_layer.sv - self-checking bench for lif_neuron_layer
module tb_lif_neuron_layer;
    localparam int N     = 4;
    localparam int IN_W  = 8;
    localparam int POT_W = 12;
    localparam int REF_W = 3;
    localparam int PMAX  = (1 << POT_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              step_en;
    logic [N*IN_W-1:0] in_cur;
    logic              cfg_we;
    logic [1:0]        cfg_addr;
    logic [POT_W-1:0]  cfg_wdata;
    logic [N-1:0]      spike;
    logic [1:0]        mon_sel;
    logic [POT_W-1:0]  mon_pot;
    logic [7:0]        spike_total;

    lif_neuron_layer #(.N_CH(N), .IN_W(IN_W), .POT_W(POT_W), .REF_W(REF_W), .THR_RST(200)) dut (
        .clk(clk), .rst_n(rst_n), .step_en(step_en), .in_cur(in_cur),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .spike(spike), .mon_sel(mon_sel), .mon_pot(mon_pot), .spike_total(spike_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int pot_m [N];
    int ref_m [N];
    int thr_m, leak_m, refp_m, mode_m, tot_m;
    logic [N-1:0] spk_m;

    typedef struct {
        int cur;
        int all;
        int spk;
        int pot;
    } vec_t;
    vec_t tab [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            pot_m[k] = 0;
            ref_m[k] = 0;
        end
        thr_m = 200; leak_m = 0; refp_m = 0; mode_m = 2; tot_m = 0; spk_m = '0;
    endtask

    task automatic do_cycle(input logic st, input logic [N*IN_W-1:0] cur, input logic we,
                            input logic [1:0] addr, input logic [POT_W-1:0] wd);
        int exp_mon, leaked, sum, c;
        step_en = st; in_cur = cur; cfg_we = we; cfg_addr = addr; cfg_wdata = wd;
        @(posedge clk);
        exp_mon = pot_m[mon_sel];
        tot_m = (tot_m + $countones(spk_m)) % 256;
        for (int k = 0; k < N; k++) begin
            spk_m[k] = 1'b0;
            if (st && mode_m >= 2) begin
                if (ref_m[k] != 0) begin
                    ref_m[k] = ref_m[k] - 1;
                    pot_m[k] = 0;
                end else begin
                    c = int'(cur[k*IN_W +: IN_W]);
                    leaked = (leak_m == 0) ? pot_m[k] : pot_m[k] - pot_m[k] / (1 << leak_m);
                    sum = leaked + c;
                    if (sum > PMAX) sum = PMAX;
                    if (sum >= thr_m) begin
                        spk_m[k] = 1'b1;
                        ref_m[k] = refp_m;
                        pot_m[k] = (mode_m % 2 == 1) ? sum - thr_m : 0;
                    end else begin
                        pot_m[k] = sum;
                    end
                end
            end
        end
        if (we) begin
            case (addr)
                2'd0: thr_m  = int'(wd);
                2'd1: leak_m = int'(wd) % 8;
                2'd2: refp_m = int'(wd) % (1 << REF_W);
                default: mode_m = int'(wd) % 4;
            endcase
        end
        #1;
        step_en = 1'b0; cfg_we = 1'b0;
        chk("spike", int'(spike), int'(spk_m));
        chk("mon_pot", int'(mon_pot), exp_mon);
        chk("spike_total", int'(spike_total), tot_m);
    endtask

    task automatic cfg(input logic [1:0] addr, input int d);
        do_cycle(1'b0, '0, 1'b1, addr, POT_W'(d));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_spike", int'(spike), 0);
        chk("rst_mon_pot", int'(mon_pot), 0);
        chk("rst_spike_total", int'(spike_total), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_sel = 2'd0;
        model_reset();
    endtask

    // Each vector is a step followed by an idle cycle so mon_pot shows the post-step potential.
    task automatic run_tab();
        logic [N*IN_W-1:0] v;
        foreach (tab[i]) begin
            v = '0;
            for (int k = 0; k < N; k++)
                if (k == 0 || tab[i].all != 0) v[k*IN_W +: IN_W] = IN_W'(tab[i].cur);
            do_cycle(1'b1, v, 1'b0, 2'd0, '0);
            chk($sformatf("tab%0d_spike", i), int'(spike[0]), tab[i].spk);
            do_cycle(1'b0, '0, 1'b0, 2'd0, '0);
            chk($sformatf("tab%0d_pot", i), int'(mon_pot), tab[i].pot);
        end
        tab.delete();
    endtask

    task automatic rand_cycles(input int n);
        logic [1:0] a;
        int d;
        for (int i = 0; i < n; i++) begin
            mon_sel = 2'($urandom_range(0, 3));
            a = 2'($urandom_range(0, 3));
            case (a)
                2'd0: d = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, 400);
                2'd3: d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 2 + $urandom_range(0, 1);
                default: d = $urandom_range(0, PMAX);
            endcase
            do_cycle(1'($urandom_range(0, 3) != 0), $urandom(),
                     1'($urandom_range(0, 4) == 0), a, POT_W'(d));
        end
    endtask

    initial begin
        rst_n = 1'b0; step_en = 1'b0; in_cur = '0; cfg_we = 1'b0;
        cfg_addr = '0; cfg_wdata = '0; mon_sel = '0;
        model_reset();
        #2;
        do_reset();

        // integration, reset mode
        cfg(2'd0, 100);
        for (int r = 0; r < 2; r++) begin
            tab.push_back('{30, 0, 0, 30});
            tab.push_back('{30, 0, 0, 60});
            tab.push_back('{30, 0, 0, 90});
            tab.push_back('{30, 0, 1, 0});
        end
        run_tab();

        // subtract mode
        do_reset();
        cfg(2'd0, 100);
        cfg(2'd3, 3);
        tab.push_back('{30, 0, 0, 30});  tab.push_back('{30, 0, 0, 60});
        tab.push_back('{30, 0, 0, 90});  tab.push_back('{30, 0, 1, 20});
        tab.push_back('{30, 0, 0, 50});  tab.push_back('{30, 0, 0, 80});
        tab.push_back('{30, 0, 1, 10});  tab.push_back('{30, 0, 0, 40});
        tab.push_back('{30, 0, 0, 70});  tab.push_back('{30, 0, 1, 0});
        run_tab();

        // leak
        do_reset();
        cfg(2'd0, 4095);
        tab.push_back('{100, 0, 0, 100});
        run_tab();
        cfg(2'd1, 2);
        tab.push_back('{0, 0, 0, 75}); tab.push_back('{0, 0, 0, 57});
        tab.push_back('{0, 0, 0, 43}); tab.push_back('{0, 0, 0, 33});
        run_tab();

        // refractory
        do_reset();
        cfg(2'd0, 50);
        cfg(2'd2, 2);
        tab.push_back('{60, 0, 1, 0}); tab.push_back('{60, 0, 0, 0});
        tab.push_back('{60, 0, 0, 0}); tab.push_back('{60, 0, 1, 0});
        tab.push_back('{60, 0, 0, 0}); tab.push_back('{60, 0, 0, 0});
        tab.push_back('{60, 0, 1, 0});
        run_tab();

        // saturation: 16 steps reach 4080, the 17th clamps to 4095 and fires on every channel
        do_reset();
        cfg(2'd0, 4095);
        for (int s = 1; s <= 17; s++)
            tab.push_back('{255, 1, (s == 17) ? 1 : 0, (s == 17) ? 0 : 255 * s});
        run_tab();
        chk("sat_spike_total", int'(spike_total), 4);

        // threshold write coinciding with a step uses the old threshold
        do_reset();
        cfg(2'd0, 100);
        for (int s = 0; s < 3; s++) do_cycle(1'b1, 32'd30, 1'b0, 2'd0, '0);
        do_cycle(1'b1, 32'd30, 1'b1, 2'd0, 12'd200);
        chk("cfg_step_old_thr", int'(spike[0]), 1);
        do_cycle(1'b1, 32'd150, 1'b0, 2'd0, '0);
        chk("cfg_step_new_thr", int'(spike[0]), 0);

        // disabled layer holds state
        cfg(2'd3, 0);
        do_cycle(1'b1, 32'd200, 1'b0, 2'd0, '0);
        chk("disabled_spike", int'(spike), 0);
        cfg(2'd3, 2);

        rand_cycles(300);

        // asynchronous reset in the middle of a step-and-write cycle
        step_en = 1'b1; in_cur = $urandom(); cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 12'd5;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_spike", int'(spike), 0);
        chk("async_mon_pot", int'(mon_pot), 0);
        chk("async_spike_total", int'(spike_total), 0);
        @(posedge clk);
        #1;
        step_en = 1'b0; cfg_we = 1'b0;
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < N; k++) begin
            mon_sel = 2'(k);
            do_cycle(1'b0, '0, 1'b0, 2'd0, '0);
            do_cycle(1'b0, '0, 1'b0, 2'd0, '0);
            chk($sformatf("async_pot%0d", k), int'(mon_pot), 0);
        end
        do_cycle(1'b1, {4{8'd150}}, 1'b0, 2'd0, '0);
        chk("async_thr_restored", int'(spike), 0);

        rand_cycles(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
